// File: rtl/puf_meas_seq_if.sv
// puf_meas_seq_if
// Bundles the host-facing controls and the oscillator-bank signals of the PUF
// measurement sequencer.
//   master : drives start/challenge/window_len and returns bank counts.
//   slave  : the sequencer; drives oscillator controls and the response.
`timescale 1ns/1ps

interface puf_meas_seq_if #(
    parameter int CNT_W     = 8,
    parameter int WIN_W     = 12,
    parameter int RESP_BITS = 8
);
    logic                 start;
    logic [4:0]           challenge;
    logic [WIN_W-1:0]     window_len;
    logic [CNT_W-1:0]     count_a;
    logic [CNT_W-1:0]     count_b;
    logic                 osc_en;
    logic                 cnt_clr;
    logic [4:0]           sel;
    logic                 busy;
    logic                 done;
    logic                 resp_valid;
    logic [RESP_BITS-1:0] response;
    logic [5:0]           tie_cnt;

    modport master (
        output start, challenge, window_len, count_a, count_b,
        input  osc_en, cnt_clr, sel, busy, done, resp_valid, response, tie_cnt
    );

    modport slave (
        input  start, challenge, window_len, count_a, count_b,
        output osc_en, cnt_clr, sel, busy, done, resp_valid, response, tie_cnt
    );
endinterface

// File: rtl/puf_meas_seq.sv
// puf_meas_seq
// Clocked measurement sequencer for the ring-oscillator PUF. For each of
// RESP_BITS challenges it clears both bank counters, enables the oscillators
// for a programmed window, lets the counters settle, then compares the counts
// into one response bit.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   meas  : puf_meas_seq_if.slave (start/challenge/window_len/count_a/count_b in;
//           osc_en/cnt_clr/sel/busy/done/resp_valid/response/tie_cnt out)
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for start; result registers hold
// CLEAR  | cnt_clr high, oscillators off (2 cycles)
// RUN    | oscillators enabled for the latched window
// SETTLE | oscillators off, counters settle (3 cycles)
// SAMPLE | compare count_a against count_b into response
// NEXT   | advance challenge or finish
// DONE   | done pulse, response marked valid
`timescale 1ns/1ps

module puf_meas_seq #(
    parameter int CNT_W     = 8,
    parameter int WIN_W     = 12,
    parameter int RESP_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    puf_meas_seq_if.slave      meas
);
    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_SAMPLE, S_NEXT, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIN_W-1:0]     tmr_q, tmr_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4:0]           sel_q, sel_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic [5:0]           tie_q, tie_d;
    logic                 rv_q, rv_d;
    logic                 osc_q, osc_d;
    logic                 clr_q, clr_d;

    logic tmr_tc;
    logic last_bit;

    assign tmr_tc   = (tmr_q == '0);
    assign last_bit = (idx_q == IDX_W'(RESP_BITS - 1));

    // State and datapath registers. osc_en/cnt_clr are flops so they are
    // glitch-free; reset clears osc_en immediately and holds the counters clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            win_q   <= WIN_W'(1);
            idx_q   <= '0;
            sel_q   <= '0;
            resp_q  <= '0;
            tie_q   <= '0;
            rv_q    <= 1'b0;
            osc_q   <= 1'b0;
            clr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            rv_q    <= rv_d;
            osc_q   <= osc_d;
            clr_q   <= clr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (meas.start) state_d = S_CLEAR;
            S_CLEAR:  if (tmr_tc)     state_d = S_RUN;
            S_RUN:    if (tmr_tc)     state_d = S_SETTLE;
            S_SETTLE: if (tmr_tc)     state_d = S_SAMPLE;
            S_SAMPLE: state_d = S_NEXT;
            S_NEXT:   state_d = last_bit ? S_DONE : S_CLEAR;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        tmr_d  = tmr_tc ? tmr_q : tmr_q - WIN_W'(1);
        win_d  = win_q;
        idx_d  = idx_q;
        sel_d  = sel_q;
        resp_d = resp_q;
        tie_d  = tie_q;
        rv_d   = rv_q;

        // Down-counter reloads on each state entry with (cycles - 1).
        if (state_d != state_q) begin
            case (state_d)
                S_CLEAR:  tmr_d = WIN_W'(1);
                S_RUN:    tmr_d = win_q - WIN_W'(1);
                S_SETTLE: tmr_d = WIN_W'(2);
                default:  tmr_d = '0;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (meas.start) begin
                    sel_d  = meas.challenge;
                    win_d  = (meas.window_len == '0) ? WIN_W'(1) : meas.window_len;
                    idx_d  = '0;
                    resp_d = '0;
                    tie_d  = '0;
                    rv_d   = 1'b0;
                end
            end
            S_SAMPLE: begin
                resp_d[idx_q] = (meas.count_a > meas.count_b);
                if ((meas.count_a == meas.count_b) && (tie_q != 6'd63))
                    tie_d = tie_q + 6'd1;
            end
            S_NEXT: begin
                if (!last_bit) begin
                    idx_d = idx_q + IDX_W'(1);
                    sel_d = sel_q + 5'd1;
                end
            end
            S_DONE:  rv_d = 1'b1;
            default: ;
        endcase

        // Registered from the next state so they line up with the state itself.
        osc_d = (state_d == S_RUN);
        clr_d = (state_d == S_CLEAR);
    end

    assign meas.osc_en     = osc_q;
    assign meas.cnt_clr    = clr_q;
    assign meas.sel        = sel_q;
    assign meas.busy       = (state_q != S_IDLE);
    assign meas.done       = (state_q == S_DONE);
    assign meas.resp_valid = rv_q;
    assign meas.response   = resp_q;
    assign meas.tie_cnt    = tie_q;

endmodule

// File: tb/tb_puf_meas_seq.sv
`timescale 1ns/1ps

module tb_puf_meas_seq;
    localparam int CNT_W = 8;
    localparam int WIN_W = 12;
    localparam int RB    = 8;

    typedef struct {
        logic [RB-1:0] resp;
        logic [5:0]    ties;
        int            done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mode    = 0;
    logic [7:0] a_tab [32];
    logic [7:0] b_tab [32];
    exp_t sb_q [$];

    always #5 clk = ~clk;

    puf_meas_seq_if #(.CNT_W(CNT_W), .WIN_W(WIN_W), .RESP_BITS(RB)) mif ();

    puf_meas_seq #(.CNT_W(CNT_W), .WIN_W(WIN_W), .RESP_BITS(RB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .meas  (mif)
    );

    // Oscillator-bank model: counts as a function of the current challenge select.
    always_comb begin
        case (mode)
            1: begin
                mif.count_a = mif.sel[0] ? 8'd100 : 8'd150;
                mif.count_b = mif.sel[0] ? 8'd150 : 8'd100;
            end
            2: begin
                mif.count_a = 8'd77;
                mif.count_b = 8'd77;
            end
            3: begin
                mif.count_a = a_tab[mif.sel];
                mif.count_b = b_tab[mif.sel];
            end
            default: begin
                mif.count_a = 8'd200;
                mif.count_b = 8'd100;
            end
        endcase
    end

    function automatic logic [7:0] bank_a(input int m, input logic [4:0] s);
        case (m)
            1:       return s[0] ? 8'd100 : 8'd150;
            2:       return 8'd77;
            3:       return a_tab[s];
            default: return 8'd200;
        endcase
    endfunction

    function automatic logic [7:0] bank_b(input int m, input logic [4:0] s);
        case (m)
            1:       return s[0] ? 8'd150 : 8'd100;
            2:       return 8'd77;
            3:       return b_tab[s];
            default: return 8'd100;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One measurement run. pulse_cyc: cycle to pulse start while busy (0 = none).
    // abort_cyc: cycle at which reset is asserted mid-run (0 = none).
    task automatic run_test(input logic [4:0] chal, input int wlen, input int m,
                            input int pulse_cyc, input int abort_cyc);
        exp_t       e, got_e;
        int         w;
        int         bit_n;
        int         run_len;
        int         viol;
        bit         seen_done;
        bit         aborted;
        logic       prev_osc;
        logic [4:0] s;
        logic [7:0] a, b;
        logic [4:0] es;

        mode = m;
        w = (wlen == 0) ? 1 : wlen;
        e.resp = '0;
        e.ties = '0;
        for (int i = 0; i < RB; i++) begin
            s = chal + 5'(i);
            a = bank_a(m, s);
            b = bank_b(m, s);
            e.resp[i] = (a > b);
            if (a == b && e.ties != 6'd63) e.ties = e.ties + 6'd1;
        end
        e.done_cyc = RB * (w + 7) + 1;
        sb_q.push_back(e);

        @(negedge clk);
        mif.challenge  = chal;
        mif.window_len = WIN_W'(wlen);
        mif.start      = 1'b1;
        @(posedge clk);
        bit_n = 0; run_len = 0; viol = 0; prev_osc = 1'b0;
        seen_done = 1'b0; aborted = 1'b0;

        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            mif.start = (k == pulse_cyc);
            if (k == 1) begin
                check("busy_rise", mif.busy, 1);
                check("rv_clear_on_start", mif.resp_valid, 0);
            end
            if (mif.osc_en && mif.cnt_clr) viol++;
            if (k == abort_cyc) begin
                check("osc_before_abort", mif.osc_en, 1);
                rst_n = 1'b0;
                #1;
                check("abort_osc_async", mif.osc_en, 0);
                check("abort_clr", mif.cnt_clr, 1);
                check("abort_rv", mif.resp_valid, 0);
                check("abort_busy", mif.busy, 0);
                check("abort_resp", mif.response, 0);
                void'(sb_q.pop_front());
                aborted = 1'b1;
                break;
            end
            if (mif.osc_en && !prev_osc) begin
                bit_n++;
                run_len = 1;
                es = chal + 5'(bit_n - 1);
                check("sel_per_bit", mif.sel, es);
                if (bit_n == 1) check("osc_first_cyc", k, 3);
            end else if (mif.osc_en) begin
                run_len++;
            end else if (prev_osc) begin
                check("osc_len", run_len, w);
            end
            prev_osc = mif.osc_en;
            if (mif.done) begin
                seen_done = 1'b1;
                got_e = sb_q.pop_front();
                check("done_cycle", k, got_e.done_cyc);
                check("response", mif.response, got_e.resp);
                check("tie_cnt", mif.tie_cnt, got_e.ties);
                check("busy_at_done", mif.busy, 1);
                check("bits_measured", bit_n, RB);
                check("osc_clr_excl", viol, 0);
                @(negedge clk);
                check("rv_after_done", mif.resp_valid, 1);
                check("done_pulse", mif.done, 0);
                check("busy_after_done", mif.busy, 0);
                check("resp_hold", mif.response, got_e.resp);
                break;
            end
        end

        if (aborted) begin
            @(negedge clk);
            mif.start = 1'b0;
            rst_n = 1'b1;
            @(negedge clk);
        end else if (!seen_done) begin
            check("done_timeout", 0, 1);
        end
        mif.start = 1'b0;
    endtask

    initial begin
        mif.start      = 1'b0;
        mif.challenge  = '0;
        mif.window_len = '0;
        for (int i = 0; i < 32; i++) begin
            a_tab[i] = 8'($urandom_range(0, 255));
            b_tab[i] = (i % 4 == 0) ? a_tab[i] : 8'($urandom_range(0, 255));
        end

        repeat (3) @(negedge clk);
        check("rst_osc", mif.osc_en, 0);
        check("rst_clr", mif.cnt_clr, 1);
        check("rst_busy", mif.busy, 0);
        check("rst_sel", mif.sel, 0);
        check("rst_done", mif.done, 0);
        check("rst_rv", mif.resp_valid, 0);
        check("rst_resp", mif.response, 0);
        check("rst_tie", mif.tie_cnt, 0);

        rst_n = 1'b1;
        #1;
        check("clr_held_before_edge", mif.cnt_clr, 1);
        @(negedge clk);
        check("clr_drop_after_release", mif.cnt_clr, 0);
        repeat (4) @(negedge clk);
        check("idle_busy", mif.busy, 0);
        check("idle_osc", mif.osc_en, 0);
        check("idle_sel", mif.sel, 0);
        check("idle_resp", mif.response, 0);

        run_test(5'd3,  4, 0, 0,  0);
        run_test(5'd30, 1, 1, 0,  0);
        run_test(5'd0,  6, 2, 0,  0);
        run_test(5'd7,  0, 0, 20, 0);
        run_test(5'd0,  8, 0, 30, 50);
        run_test(5'd17, 2, 3, 0,  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
